// File: rtl/ahb_ws_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the wait-state SRAM slave.
package ahb_ws_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_ws_lane_dec.sv
// Byte-lane strobe and alignment/size error decode for one AHB beat (little-endian).
// Purely combinational, zero latency, no flow control.
module ahb_ws_lane_dec
  import ahb_ws_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] offset,
  output logic [3:0] strb,
  output logic       align_err
);

  always_comb begin
    strb      = 4'b0000;
    align_err = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << offset;
      HSIZE_HALF: begin
        strb      = offset[1] ? 4'b1100 : 4'b0011;
        align_err = offset[0];
      end
      HSIZE_WORD: begin
        strb      = 4'b1111;
        align_err = |offset;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_ws_slave.sv
// AHB-Lite SRAM slave: OKAY after WAIT_STATES stall cycles, two-cycle ERROR on bad beats.
// HREADYOUT is the only backpressure; AHB_WS_PROTECT_EN write-protects words 0..RO_WORDS-1.
module ahb_ws_slave
  import ahb_ws_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 16,
  parameter int WAIT_STATES = 2,
  parameter int RO_WORDS    = 4
) (
  input  logic              HCLK,
  input  logic              HRESTn,
  input  logic              HSELx,
  input  logic              HREADY,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HBURST,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       strb_q;
  logic             wr_q;
  logic [31:0]      hrdata_q;
  logic [31:0]      mem [MEM_WORDS];

  logic [IDX_W-1:0] idx;
  logic [3:0]       strb;
  logic             align_err, ro_hit, prot_err, bad, accept;

  assign idx = HADDR[IDX_W+1:2];

  ahb_ws_lane_dec u_lane_dec (
    .size      (HSIZE),
    .offset    (HADDR[1:0]),
    .strb      (strb),
    .align_err (align_err)
  );

  assign ro_hit = int'(idx) < RO_WORDS;
`ifdef AHB_WS_PROTECT_EN
  assign prot_err = HWRITE & ro_hit;
`else
  assign prot_err = 1'b0;
`endif
  assign bad = align_err | prot_err;

  // New beats are only taken while no stall cycle is being driven.
  assign accept = (state == ST_IDLE || state == ST_DONE || state == ST_ERR2)
                  & HSELx & HREADY & HTRANS[1];

  logic unused_bits;
  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[ADDR_W-1:IDX_W+2], ro_hit};

  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept)             state_nxt = ST_IDLE;
        else if (bad)            state_nxt = ST_ERR1;
        else if (WAIT_STATES == 0) state_nxt = ST_DONE;
        else                     state_nxt = ST_WAIT;
      end
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      cnt    <= 4'd0;
      idx_q  <= '0;
      strb_q <= 4'b0000;
      wr_q   <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_INIT;
      idx_q  <= idx;
      strb_q <= strb;
      wr_q   <= HWRITE;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Write commits at the end of DONE using the beat captured at accept time.
  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
      hrdata_q <= 32'h0;
    end else if (state == ST_DONE) begin
      if (wr_q) begin
        for (int b = 0; b < 4; b++)
          if (strb_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end else begin
        hrdata_q <= mem[idx_q];
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = hrdata_q;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      ST_DONE: if (!wr_q) HRDATA = mem[idx_q];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_ws_slave.sv
// Directed bench: slave A uses 2 wait states, slave B is zero-wait for the INCR burst.
module tb_ahb_ws_slave;
  import ahb_ws_pkg::*;

  logic        HCLK, HRESTn, sel_a, sel_b, HREADY, HWRITE, HBURST;
  logic [31:0] HADDR, HWDATA, rdata_a, rdata_b;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        rdy_a, rdy_b, resp_a, resp_b;

  int n_assert = 0;
  int n_fail   = 0;

  assign HREADY = rdy_a & rdy_b;

  ahb_ws_slave #(.ADDR_W(32), .MEM_WORDS(16), .WAIT_STATES(2), .RO_WORDS(4)) u_a (
    .HCLK(HCLK), .HRESTn(HRESTn), .HSELx(sel_a), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(rdata_a), .HREADYOUT(rdy_a), .HRESP(resp_a)
  );

  ahb_ws_slave #(.ADDR_W(32), .MEM_WORDS(16), .WAIT_STATES(0), .RO_WORDS(0)) u_b (
    .HCLK(HCLK), .HRESTn(HRESTn), .HSELx(sel_b), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(rdata_b), .HREADYOUT(rdy_b), .HRESP(resp_b)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One non-pipelined transfer; counts stall cycles of the data phase.
  task automatic xfer(input bit b, input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output int lows, output logic r_first,
                      output logic r_last, output logic [31:0] rd);
    int cyc;
    @(posedge HCLK); #1;
    sel_a = !b; sel_b = b; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = w; HSIZE = sz; HBURST = 1'b0;
    @(posedge HCLK); #1;
    sel_a = 1'b0; sel_b = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wd;
    lows = 0; cyc = 0;
    @(negedge HCLK);
    r_first = b ? resp_b : resp_a;
    while (!(b ? rdy_b : rdy_a) && cyc < 40) begin
      lows++; cyc++;
      @(negedge HCLK);
    end
    if (cyc >= 40) lows = 99;
    r_last = b ? resp_b : resp_a;
    rd     = b ? rdata_b : rdata_a;
  endtask

  task automatic do_wr(input bit b, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                       input int exp_lows, input logic exp_err, input string tag);
    int lows; logic rf, rl; logic [31:0] rd;
    xfer(b, 1'b1, a, sz, wd, lows, rf, rl, rd);
    chk({tag, "_stall"}, 32'(lows), 32'(exp_lows));
    chk({tag, "_resp1"}, {31'h0, rf}, {31'h0, exp_err});
    chk({tag, "_resp2"}, {31'h0, rl}, {31'h0, exp_err});
  endtask

  task automatic do_rd(input bit b, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp_d,
                       input int exp_lows, input logic exp_err, input string tag);
    int lows; logic rf, rl; logic [31:0] rd;
    xfer(b, 1'b0, a, sz, 32'h0, lows, rf, rl, rd);
    chk({tag, "_stall"}, 32'(lows), 32'(exp_lows));
    chk({tag, "_resp1"}, {31'h0, rf}, {31'h0, exp_err});
    chk({tag, "_resp2"}, {31'h0, rl}, {31'h0, exp_err});
    if (!exp_err) chk({tag, "_data"}, rd, exp_d);
  endtask

  initial begin
    sel_a = 0; sel_b = 0; HADDR = 0; HTRANS = HTRANS_IDLE; HWRITE = 0;
    HSIZE = HSIZE_WORD; HBURST = 0; HWDATA = 0;
    HRESTn = 1'b1;
    #2 HRESTn = 1'b0;
    #10;
    chk("reset_ready", {31'h0, rdy_a}, 32'h1);
    chk("reset_resp",  {31'h0, resp_a}, 32'h0);
    chk("reset_rdata", rdata_a, 32'h0);
    #10 HRESTn = 1'b1;

    do_wr(0, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 2, 0, "wr_word");
    do_rd(0, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 2, 0, "rd_word");
    @(negedge HCLK);
    chk("rdata_hold", rdata_a, 32'hDEADBEEF);

    do_wr(0, 32'h10, HSIZE_WORD, 32'h11223344, 2, 0, "wr_base");
    do_wr(0, 32'h13, HSIZE_BYTE, 32'hAA000000, 2, 0, "wr_byte");
    do_rd(0, 32'h10, HSIZE_WORD, 32'hAA223344, 2, 0, "rd_byte_merge");
    do_wr(0, 32'h16, HSIZE_HALF, 32'hBEEF0000, 2, 0, "wr_half");
    do_rd(0, 32'h14, HSIZE_WORD, 32'hBEEF0000, 2, 0, "rd_half_merge");

    do_rd(0, 32'h11, HSIZE_HALF, 32'h0, 1, 1, "rd_half_misalign");
    do_wr(0, 32'h12, HSIZE_WORD, 32'hFFFFFFFF, 1, 1, "wr_word_misalign");
    do_rd(0, 32'h10, 3'b011, 32'h0, 1, 1, "rd_bad_size");
    do_rd(0, 32'h10, HSIZE_WORD, 32'hAA223344, 2, 0, "rd_after_errors");

`ifdef AHB_WS_PROTECT_EN
    do_wr(0, 32'h08, HSIZE_WORD, 32'h5, 1, 1, "wr_protected");
    do_rd(0, 32'h08, HSIZE_WORD, 32'h0, 2, 0, "rd_protected");
`else
    do_wr(0, 32'h08, HSIZE_WORD, 32'h5, 2, 0, "wr_unprotected");
    do_rd(0, 32'h08, HSIZE_WORD, 32'h5, 2, 0, "rd_unprotected");
`endif

    do_wr(0, 32'h50, HSIZE_WORD, 32'hCAFEF00D, 2, 0, "wr_wrap");
    do_rd(0, 32'h10, HSIZE_WORD, 32'hCAFEF00D, 2, 0, "rd_wrap");

    do_wr(1, 32'h00, HSIZE_WORD, 32'h00001111, 0, 0, "b_wr0");
    do_wr(1, 32'h04, HSIZE_WORD, 32'h22223333, 0, 0, "b_wr1");
    do_wr(1, 32'h08, HSIZE_WORD, 32'h44445555, 0, 0, "b_wr2");

    // Pipelined INCR burst on the zero-wait slave.
    @(posedge HCLK); #1;
    sel_b = 1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h00; HWRITE = 0; HSIZE = HSIZE_WORD; HBURST = 1;
    @(posedge HCLK); #1;
    HTRANS = HTRANS_SEQ; HADDR = 32'h04;
    @(negedge HCLK);
    chk("burst0_ready", {31'h0, rdy_b}, 32'h1);
    chk("burst0_data", rdata_b, 32'h00001111);
    @(posedge HCLK); #1;
    HADDR = 32'h08;
    @(negedge HCLK);
    chk("burst1_ready", {31'h0, rdy_b}, 32'h1);
    chk("burst1_data", rdata_b, 32'h22223333);
    @(posedge HCLK); #1;
    sel_b = 0; HTRANS = HTRANS_IDLE; HBURST = 0;
    @(negedge HCLK);
    chk("burst2_ready", {31'h0, rdy_b}, 32'h1);
    chk("burst2_resp", {31'h0, resp_b}, 32'h0);
    chk("burst2_data", rdata_b, 32'h44445555);

    // Reset asserted in the middle of a stalled write.
    @(posedge HCLK); #1;
    sel_a = 1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h14; HWRITE = 1; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    sel_a = 0; HTRANS = HTRANS_IDLE; HWDATA = 32'h12345678;
    @(negedge HCLK);
    chk("wait_stall", {31'h0, rdy_a}, 32'h0);
    #2 HRESTn = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, rdy_a}, 32'h1);
    chk("midrst_resp", {31'h0, resp_a}, 32'h0);
    chk("midrst_rdata", rdata_a, 32'h0);
    #4 HRESTn = 1'b1;

    do_rd(0, 32'h14, HSIZE_WORD, 32'h0, 2, 0, "rd_post_reset_a");
    do_rd(1, 32'h04, HSIZE_WORD, 32'h0, 0, 0, "rd_post_reset_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
